// File: rtl/gumnut_inst_prefetch.sv
// rtl/gumnut_inst_prefetch.sv - sequential instruction prefetch FIFO between core and instruction memory
// Optional hit/miss counters: GUMNUT_PREFETCH_STATS_EN
module gumnut_inst_prefetch #(
  parameter int          DEPTH      = 4,
  parameter logic [11:0] RESET_ADDR = 12'h000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        inst_cyc_i,
  input  logic        inst_stb_i,
  input  logic [11:0] inst_addr_i,
  output logic [17:0] inst_dat_o,
  output logic        inst_ack_o,
  output logic        mem_cyc_o,
  output logic        mem_stb_o,
  output logic [11:0] mem_addr_o,
  input  logic [17:0] mem_dat_i,
  input  logic        mem_ack_i
`ifdef GUMNUT_PREFETCH_STATS_EN
  ,
  output logic [15:0] hit_cnt_o,
  output logic [15:0] miss_cnt_o
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t        state, state_next;
  logic [17:0]   fifo [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count, count_next;
  logic [11:0]   head_addr, head_next;
  logic [11:0]   fetch_addr, fetch_next;
  logic          req, miss, hit, pending, data_ret, bypass, push, room, issue;

  always_comb begin
    req      = inst_cyc_i & inst_stb_i & ~inst_ack_o;
    miss     = req & (inst_addr_i != head_addr);
    hit      = req & ~miss & (count != '0);
    pending  = req & ~miss & (count == '0);
    data_ret = (state == FETCH) & mem_ack_i;
    // With an empty buffer the returning word is always the head, so hand it straight to the core.
    bypass   = pending & data_ret;
    push     = data_ret & ~miss & ~bypass;

    if (miss)              count_next = '0;
    else if (push & ~hit)  count_next = count + CW'(1);
    else if (hit & ~push)  count_next = count - CW'(1);
    else                   count_next = count;

    head_next  = miss ? inst_addr_i : ((hit | bypass) ? head_addr + 12'd1 : head_addr);
    fetch_next = miss ? inst_addr_i : (data_ret ? fetch_addr + 12'd1 : fetch_addr);
    room       = count_next < CW'(DEPTH);
  end

  always_comb begin
    state_next = state;
    issue      = 1'b0;
    mem_cyc_o  = (state != IDLE);
    mem_stb_o  = (state != IDLE);
    case (state)
      IDLE: begin
        if (room) begin
          state_next = FETCH;
          issue      = 1'b1;
        end
      end
      FETCH: begin
        if (mem_ack_i) begin
          if (miss)      state_next = IDLE;
          else if (room) issue      = 1'b1;
          else           state_next = IDLE;
        end else if (miss) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (mem_ack_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count      <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      head_addr  <= RESET_ADDR;
      fetch_addr <= RESET_ADDR;
      mem_addr_o <= '0;
      inst_ack_o <= 1'b0;
      inst_dat_o <= '0;
    end else begin
      count      <= count_next;
      head_addr  <= head_next;
      fetch_addr <= fetch_next;
      inst_ack_o <= hit | bypass;
      if (issue)       mem_addr_o <= fetch_next;
      if (hit)         inst_dat_o <= fifo[rd_ptr];
      else if (bypass) inst_dat_o <= mem_dat_i;
      if (miss) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (hit)  rd_ptr <= rd_ptr + AW'(1);
        if (push) wr_ptr <= wr_ptr + AW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) fifo[wr_ptr] <= mem_dat_i;
  end

`ifdef GUMNUT_PREFETCH_STATS_EN
  // waiting marks a request already evaluated once, so late acks are not counted as hits
  logic waiting;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      waiting    <= 1'b0;
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
    end else begin
      waiting <= req & ~(hit | bypass);
      if (hit & ~waiting & (hit_cnt_o != 16'hFFFF)) hit_cnt_o  <= hit_cnt_o + 16'd1;
      if (miss & (miss_cnt_o != 16'hFFFF))          miss_cnt_o <= miss_cnt_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_gumnut_inst_prefetch.sv
// tb/tb_gumnut_inst_prefetch.sv - scoreboard bench for gumnut_inst_prefetch
`timescale 1ns/1ps
module tb_gumnut_inst_prefetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cyc = 1'b0;
  logic        stb = 1'b0;
  logic [11:0] addr = 12'h000;
  logic [17:0] inst_dat;
  logic        inst_ack;
  logic        mem_cyc, mem_stb;
  logic [11:0] mem_addr;
  logic [17:0] mem_dat = 18'h0;
  logic        mem_ack = 1'b0;
`ifdef GUMNUT_PREFETCH_STATS_EN
  logic [15:0] hit_cnt, miss_cnt;
`endif

  int checks = 0;
  int failures = 0;
  int mem_lat = 1;
  int wcnt = 0;
  logic [17:0] exp_q[$];
  logic [11:0] mem_log[$];
  logic        prev_stb = 1'b0;
  logic [11:0] prev_addr = 12'h000;

  always #5 clk = ~clk;

  gumnut_inst_prefetch dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .inst_cyc_i (cyc),
    .inst_stb_i (stb),
    .inst_addr_i(addr),
    .inst_dat_o (inst_dat),
    .inst_ack_o (inst_ack),
    .mem_cyc_o  (mem_cyc),
    .mem_stb_o  (mem_stb),
    .mem_addr_o (mem_addr),
    .mem_dat_i  (mem_dat),
    .mem_ack_i  (mem_ack)
`ifdef GUMNUT_PREFETCH_STATS_EN
    ,
    .hit_cnt_o  (hit_cnt),
    .miss_cnt_o (miss_cnt)
`endif
  );

  function automatic logic [17:0] word(input logic [11:0] a);
    return {a[5:0] ^ 6'h2D, a};
  endfunction

  function automatic logic [11:0] log_at(input int i);
    if (i >= 0 && i < mem_log.size()) return mem_log[i];
    return 12'hxxx;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Memory responder, core-ack scoreboard and bus-hold monitor share one negedge process for ordering.
  always @(negedge clk) begin
    if (inst_ack) begin
      if (exp_q.size() == 0) check("spurious_ack", {31'b0, inst_ack}, 32'd0);
      else                   check("inst_dat", {14'b0, inst_dat}, {14'b0, exp_q.pop_front()});
    end
    if (!rst && prev_stb && !mem_ack && mem_stb)
      check("bus_hold", {20'b0, mem_addr}, {20'b0, prev_addr});
    prev_stb  = mem_stb;
    prev_addr = mem_addr;
    if (rst || !mem_stb) begin
      mem_ack = 1'b0;
      wcnt    = 0;
    end else if (wcnt + 1 >= mem_lat) begin
      mem_ack = 1'b1;
      mem_dat = word(mem_addr);
      wcnt    = 0;
      mem_log.push_back(mem_addr);
    end else begin
      mem_ack = 1'b0;
      wcnt++;
    end
  end

  task automatic idle(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic core_fetch(input logic [11:0] a, input int exp_lat, input string tag);
    int n;
    n = 0;
    @(negedge clk);
    cyc = 1'b1;
    stb = 1'b1;
    addr = a;
    exp_q.push_back(word(a));
    do begin
      @(negedge clk);
      n++;
    end while (!inst_ack && n < 40);
    cyc = 1'b0;
    stb = 1'b0;
    if (!inst_ack) begin
      check({tag, "_timeout"}, {31'b0, inst_ack}, 32'd1);
      void'(exp_q.pop_back());
    end else if (exp_lat > 0) begin
      check({tag, "_lat"}, n, exp_lat);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int k;
    int n;
    repeat (2) @(negedge clk);
    check("rst_inst_ack", {31'b0, inst_ack}, 32'd0);
    check("rst_inst_dat", {14'b0, inst_dat}, 32'd0);
    check("rst_mem_cyc", {31'b0, mem_cyc}, 32'd0);
    check("rst_mem_stb", {31'b0, mem_stb}, 32'd0);
    check("rst_mem_addr", {20'b0, mem_addr}, 32'd0);
    rst = 1'b0;

    // fill to DEPTH with the core quiet, then sequential hits
    idle(10);
    check("full_stb_low", {31'b0, mem_stb}, 32'd0);
    check("full_cyc_low", {31'b0, mem_cyc}, 32'd0);
    core_fetch(12'h000, 1, "t1_a0");
    check("refetch_after_pop", {31'b0, mem_stb}, 32'd1);
    for (int i = 1; i < 16; i++) core_fetch(12'(i), 1, "seq");
    idle(6);
`ifdef GUMNUT_PREFETCH_STATS_EN
    check("stat_hit16", {16'b0, hit_cnt}, 32'd16);
    check("stat_miss0", {16'b0, miss_cnt}, 32'd0);
`endif

    // miss from a full buffer at head 0x010
    core_fetch(12'h080, 2, "t2_miss");
    check("t2_next_addr", {20'b0, mem_addr}, 32'h081);
`ifdef GUMNUT_PREFETCH_STATS_EN
    check("stat_miss1", {16'b0, miss_cnt}, 32'd1);
`endif

    // miss during an outstanding slow transfer forces a drain
    idle(6);
    mem_lat = 3;
    core_fetch(12'h200, 4, "t3_first");
    mem_log.delete();
    core_fetch(12'h300, 6, "t3_drain");
    check("t3_log0", {20'b0, log_at(0)}, 32'h201);
    check("t3_log1", {20'b0, log_at(1)}, 32'h300);

    // address wrap 0xFFE -> 0xFFF -> 0x000
    mem_lat = 1;
    mem_log.delete();
    core_fetch(12'hFFE, -1, "t4_miss");
    idle(6);
    k = -1;
    for (int i = mem_log.size() - 1; i >= 0; i--) if (mem_log[i] == 12'hFFE) k = i;
    check("t4_found", {31'b0, k >= 0}, 32'd1);
    check("t4_wrap1", {20'b0, log_at(k + 1)}, 32'hFFF);
    check("t4_wrap2", {20'b0, log_at(k + 2)}, 32'h000);
    core_fetch(12'hFFF, 1, "t4_fff");
    core_fetch(12'h000, 1, "t4_000");
    idle(2);
`ifdef GUMNUT_PREFETCH_STATS_EN
    check("stat_hit18", {16'b0, hit_cnt}, 32'd18);
    check("stat_miss4", {16'b0, miss_cnt}, 32'd4);
`endif

    // asynchronous reset in the middle of a transfer
    idle(6);
    mem_lat = 3;
    core_fetch(12'h001, 1, "t6_hit");
    check("t6_mid_fetch", {31'b0, mem_stb}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("t6_mem_cyc", {31'b0, mem_cyc}, 32'd0);
    check("t6_mem_stb", {31'b0, mem_stb}, 32'd0);
    check("t6_mem_addr", {20'b0, mem_addr}, 32'd0);
    check("t6_inst_ack", {31'b0, inst_ack}, 32'd0);
    check("t6_inst_dat", {14'b0, inst_dat}, 32'd0);
`ifdef GUMNUT_PREFETCH_STATS_EN
    check("t6_hit_clr", {16'b0, hit_cnt}, 32'd0);
    check("t6_miss_clr", {16'b0, miss_cnt}, 32'd0);
`endif
    idle(2);
    mem_lat = 1;
    rst = 1'b0;
    n = 0;
    while (!mem_stb && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("t6_restart_stb", {31'b0, mem_stb}, 32'd1);
    check("t6_first_addr", {20'b0, mem_addr}, 32'h000);
    core_fetch(12'h000, -1, "t6_a0");
    core_fetch(12'h001, 1, "t6_a1");
    idle(4);
    check("final_queue_empty", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gumnut_inst_prefetch.md
Name: gumnut_inst_prefetch

Overview:
Instruction-side prefetch buffer between the Gumnut core's instruction bus and instruction memory. It fetches sequential 18-bit instruction words into a small FIFO ahead of the core and answers core fetches from the buffer in one cycle on a hit. On a non-sequential address (jump, branch, interrupt vector, return) it flushes the buffer and redirects to the requested address. Both sides use the core's Wishbone-style cyc/stb/ack handshake.

Parameters:
DEPTH, 4, buffer entries; power of two, 2..16
RESET_ADDR, 12'h000, first address prefetched after reset

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
inst_cyc_i  in  1  core bus cycle
inst_stb_i  in  1  core strobe
inst_addr_i  in  12  core fetch address
inst_dat_o  out  18  instruction to core
inst_ack_o  out  1  fetch acknowledge, one-cycle pulse
mem_cyc_o  out  1  memory bus cycle
mem_stb_o  out  1  memory strobe
mem_addr_o  out  12  memory address
mem_dat_i  in  18  memory read data
mem_ack_i  in  1  memory acknowledge
hit_cnt_o  out  16  hits, only with GUMNUT_PREFETCH_STATS_EN
miss_cnt_o  out  16  misses, only with GUMNUT_PREFETCH_STATS_EN

Behaviour:
- State: FIFO of DEPTH data words; head_addr (address of oldest entry); count (0..DEPTH); fetch_addr (next address to request). All address arithmetic is 12-bit modulo: 12'hFFF + 1 = 12'h000.
- Reset (async): count=0, head_addr=fetch_addr=RESET_ADDR, memory FSM=IDLE. All outputs 0.
- Core request = inst_cyc_i & inst_stb_i & ~inst_ack_o.
- Hit: request and count>0 and inst_addr_i==head_addr. Next cycle: inst_ack_o=1, inst_dat_o=head word. Pop the entry and increment head_addr. Latency is exactly 1 cycle.
- Pending: request, count==0, inst_addr_i==head_addr. No ack. Wait until the entry lands, then ack on the following cycle.
- Miss: request and inst_addr_i != head_addr. Set count=0, head_addr=inst_addr_i, fetch_addr=inst_addr_i. If a memory transfer is outstanding, go to DRAIN. The request then proceeds as pending.
- If the core drops stb before ack, the request is cancelled: nothing is popped, and the buffer is kept.
- inst_ack_o and inst_dat_o are registered. inst_dat_o holds its last value when ack is low.
- Memory FSM:
  - IDLE: if count<DEPTH, assert mem_cyc_o/mem_stb_o with mem_addr_o=fetch_addr and go to FETCH.
  - FETCH: hold cyc/stb/addr stable until mem_ack_i.
    - On ack: push mem_dat_i, fetch_addr+1.
    - Then, if count after push < DEPTH, issue the next address the same cycle (back-to-back, stay in FETCH); otherwise deassert and go to IDLE.
  - DRAIN: hold the bus until mem_ack_i, discard the data, then go to IDLE (fetch_addr already redirected). No abort mid-transfer.
- Full (count==DEPTH): no new memory request. Fetching resumes the cycle after a pop.
- Simultaneous pop and push: count unchanged, and both take effect.
- Miss in the same cycle as mem_ack_i in FETCH: the acked data is discarded, the flush wins, and the FSM goes to IDLE (no DRAIN needed).
- A push can never land in a full FIFO: a request is only issued when count<DEPTH.

Optional Feature:
GUMNUT_PREFETCH_STATS_EN
- Defined:
  - hit_cnt_o and miss_cnt_o exist. Both are 16-bit saturating at 16'hFFFF and reset to 0.
  - hit_cnt_o increments on each ack whose request was a hit at first evaluation.
  - miss_cnt_o increments on each miss event.
- Undefined: the ports and counters are absent, and there is no other change.

Test Plan:
1. Reset, then a core request at 0x000 with the memory acking in 1 cycle. The buffer fills with words for 0x000..0x003 and mem_cyc_o drops. Sequential requests 0x000..0x003 each ack 1 cycle after stb with the matching data.
2. Buffer full at head 0x010, then a request at 0x080. Flush, then mem_addr_o=0x080. The core is acked with word 0x080 one cycle after mem_ack_i; prefetch continues from 0x081. Stats: miss_cnt_o=1.
3. Miss while FETCH is outstanding and mem_ack_i is delayed 3 cycles. The FSM goes to DRAIN, and the bus holds the old address until ack. The stale data never reaches inst_dat_o; the next mem_addr_o is the new target.
4. Start at 0xFFE with sequential fetches. mem_addr_o goes 0xFFE, 0xFFF, 0x000. Core requests at 0xFFF then 0x000 both hit.
5. The core holds stb low while memory acks continuously. count reaches DEPTH and mem_stb_o stays 0. After one hit pop, mem_stb_o re-asserts on the next cycle.
6. Assert rst_i mid-FETCH. All outputs go to 0 immediately. After release, the first mem_addr_o is RESET_ADDR.
